// File: rtl/ula8_seq_ctrl_pkg.sv
// Shared definitions for the 8-bit sequencer around the 4-bit ULA slice:
// FSM state encoding, slice select codes and the nibble width.
package ula_defs;

   localparam int NIBBLE_W = 4;
   localparam int WORD_W   = 2 * NIBBLE_W;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HI   = 2'b01,
      LO   = 2'b10,
      DONE = 2'b11
   } state_e;

   // Select codes as seen on {X2, X1, X0} of the slice.
   localparam logic [2:0] OP_PASS_A = 3'b000;
   localparam logic [2:0] OP_PASS_B = 3'b001;
   localparam logic [2:0] OP_AND    = 3'b010;
   localparam logic [2:0] OP_OR     = 3'b011;
   localparam logic [2:0] OP_XOR    = 3'b100;
   localparam logic [2:0] OP_NOT_A  = 3'b101;
   localparam logic [2:0] OP_ADD    = 3'b110;
   localparam logic [2:0] OP_SUB    = 3'b111;

endpackage

// File: rtl/ula8_merge.sv
// Combines the high and low nibble captures of the slice into the 8-bit
// result and compare flags, including the early-exit compare case.
module ula8_merge
   import ula_defs::*;
(
   input  logic                cmp_i,
   input  logic                early_i,
   input  logic [NIBBLE_W-1:0] f_hi_i,
   input  logic [NIBBLE_W-1:0] f_lo_i,
   input  logic                igual_hi_i,
   input  logic                menor_hi_i,
   input  logic                igual_lo_i,
   input  logic                menor_lo_i,
   output logic [WORD_W-1:0]   result_o,
   output logic                igual_o,
   output logic                menor_o
);

   always_comb begin
      result_o = '0;
      igual_o  = 1'b0;
      menor_o  = 1'b0;
      if (!cmp_i) begin
         result_o = {f_hi_i, f_lo_i};
      end else if (early_i) begin
         // High nibbles already differ, so the high compare decides alone.
         menor_o = menor_hi_i;
      end else begin
         igual_o = igual_hi_i & igual_lo_i;
         menor_o = menor_hi_i | (igual_hi_i & menor_lo_i);
      end
   end

endmodule

// File: rtl/ula8_seq_ctrl.sv
// 8-bit operation sequencer over a shared 4-bit ULA slice (high nibble, then
// low nibble). Define ULA_SEQ_EARLY_EXIT_EN to finish compares after HI when
// the high nibbles differ.
module ula8_seq_ctrl
   import ula_defs::*;
(
   input  logic                clock_i,
   input  logic                reset_ni,
   input  logic                start_i,
   input  logic [2:0]          op_i,
   input  logic                cmp_i,
   input  logic [WORD_W-1:0]   a_i,
   input  logic [WORD_W-1:0]   b_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [WORD_W-1:0]   result_o,
   output logic                igual_o,
   output logic                menor_o,
   output logic [NIBBLE_W-1:0] ula_a_o,
   output logic [NIBBLE_W-1:0] ula_b_o,
   output logic                ula_x0_o,
   output logic                ula_x1_o,
   output logic                ula_x2_o,
   input  logic [NIBBLE_W-1:0] ula_f_i,
   input  logic                ula_igual_i,
   input  logic                ula_menor_i
);

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   a_q, b_q;
   logic [2:0]          op_q;
   logic                cmp_q;
   logic [NIBBLE_W-1:0] f_hi_q, f_lo_q;
   logic                igual_hi_q, menor_hi_q, igual_lo_q, menor_lo_q;
   logic [WORD_W-1:0]   result_q;
   logic                igual_q, menor_q;

   logic                accept, cap_hi, cap_lo, finish, early;
   logic [2:0]          sel;
   logic [NIBBLE_W-1:0] m_f_hi, m_f_lo;
   logic                m_igual_hi, m_menor_hi, m_igual_lo, m_menor_lo;
   logic [WORD_W-1:0]   m_result;
   logic                m_igual, m_menor;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      cap_hi  = 1'b0;
      cap_lo  = 1'b0;
      finish  = 1'b0;
      early   = 1'b0;
      ula_a_o = '0;
      ula_b_o = '0;
      sel     = '0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               accept  = 1'b1;
               state_d = HI;
            end
         end
         HI: begin
            ula_a_o = a_q[WORD_W-1:NIBBLE_W];
            ula_b_o = b_q[WORD_W-1:NIBBLE_W];
            sel     = op_q;
            cap_hi  = 1'b1;
            state_d = LO;
`ifdef ULA_SEQ_EARLY_EXIT_EN
            if (cmp_q && !ula_igual_i) begin
               early   = 1'b1;
               finish  = 1'b1;
               state_d = DONE;
            end
`endif
         end
         LO: begin
            ula_a_o = a_q[NIBBLE_W-1:0];
            ula_b_o = b_q[NIBBLE_W-1:0];
            sel     = op_q;
            cap_lo  = 1'b1;
            finish  = 1'b1;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ula_x0_o = sel[0];
   assign ula_x1_o = sel[1];
   assign ula_x2_o = sel[2];

   // Merge sees this cycle's slice outputs so results are valid in DONE.
   assign m_f_hi     = cap_hi ? ula_f_i     : f_hi_q;
   assign m_igual_hi = cap_hi ? ula_igual_i : igual_hi_q;
   assign m_menor_hi = cap_hi ? ula_menor_i : menor_hi_q;
   assign m_f_lo     = cap_lo ? ula_f_i     : f_lo_q;
   assign m_igual_lo = cap_lo ? ula_igual_i : igual_lo_q;
   assign m_menor_lo = cap_lo ? ula_menor_i : menor_lo_q;

   ula8_merge u_merge (
      .cmp_i      (cmp_q),
      .early_i    (early),
      .f_hi_i     (m_f_hi),
      .f_lo_i     (m_f_lo),
      .igual_hi_i (m_igual_hi),
      .menor_hi_i (m_menor_hi),
      .igual_lo_i (m_igual_lo),
      .menor_lo_i (m_menor_lo),
      .result_o   (m_result),
      .igual_o    (m_igual),
      .menor_o    (m_menor)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         cmp_q      <= 1'b0;
         f_hi_q     <= '0;
         f_lo_q     <= '0;
         igual_hi_q <= 1'b0;
         menor_hi_q <= 1'b0;
         igual_lo_q <= 1'b0;
         menor_lo_q <= 1'b0;
         result_q   <= '0;
         igual_q    <= 1'b0;
         menor_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q   <= a_i;
            b_q   <= b_i;
            op_q  <= op_i;
            cmp_q <= cmp_i;
         end
         if (cap_hi) begin
            f_hi_q     <= ula_f_i;
            igual_hi_q <= ula_igual_i;
            menor_hi_q <= ula_menor_i;
         end
         if (cap_lo) begin
            f_lo_q     <= ula_f_i;
            igual_lo_q <= ula_igual_i;
            menor_lo_q <= ula_menor_i;
         end
         if (finish) begin
            result_q <= m_result;
            igual_q  <= m_igual;
            menor_q  <= m_menor;
         end
      end
   end

   assign busy_o   = (state_q != IDLE);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;
   assign igual_o  = igual_q;
   assign menor_o  = menor_q;

endmodule

// File: tb/tb_ula8_seq_ctrl.sv
// Bench for ula8_seq_ctrl: a nibble-slice model, a timeline reference model
// checked every cycle, and directed operations with hand-computed results.
module tb_ula8_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cmp = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] a = 8'h00, b = 8'h00;
   logic       busy, done, igual, menor;
   logic [7:0] result;
   logic [3:0] ula_a, ula_b, ula_f;
   logic       x0, x1, x2, ula_igual, ula_menor;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ula8_seq_ctrl dut (
      .clock_i     (clk),
      .reset_ni    (rst_n),
      .start_i     (start),
      .op_i        (op),
      .cmp_i       (cmp),
      .a_i         (a),
      .b_i         (b),
      .busy_o      (busy),
      .done_o      (done),
      .result_o    (result),
      .igual_o     (igual),
      .menor_o     (menor),
      .ula_a_o     (ula_a),
      .ula_b_o     (ula_b),
      .ula_x0_o    (x0),
      .ula_x1_o    (x1),
      .ula_x2_o    (x2),
      .ula_f_i     (ula_f),
      .ula_igual_i (ula_igual),
      .ula_menor_i (ula_menor)
   );

   function automatic logic [3:0] slice_f(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y);
      case (s)
         3'b000:  return x;
         3'b001:  return y;
         3'b010:  return x & y;
         3'b011:  return x | y;
         3'b100:  return x ^ y;
         3'b101:  return ~x;
         3'b110:  return x + y;
         default: return x - y;
      endcase
   endfunction

   always_comb begin
      ula_f     = slice_f({x2, x1, x0}, ula_a, ula_b);
      ula_igual = (ula_a == ula_b);
      ula_menor = (ula_a < ula_b);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycles since acceptance, with latency from the rules.
   int         m_phase, m_lat;
   logic [7:0] m_a, m_b, m_result;
   logic [2:0] m_op;
   logic       m_cmp, m_igual, m_menor;

   function automatic int latency_of(input logic c, input logic [7:0] x, input logic [7:0] y);
`ifdef ULA_SEQ_EARLY_EXIT_EN
      if (c && (x[7:4] != y[7:4])) return 2;
`endif
      return 3;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_lat <= 3;
         m_a <= 8'h00; m_b <= 8'h00; m_op <= 3'b000; m_cmp <= 1'b0;
         m_result <= 8'h00; m_igual <= 1'b0; m_menor <= 1'b0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase <= 1;
            m_a <= a; m_b <= b; m_op <= op; m_cmp <= cmp;
            m_lat <= latency_of(cmp, a, b);
         end
      end else if (m_phase == m_lat) begin
         m_phase <= 0;
      end else begin
         m_phase <= m_phase + 1;
         if (m_phase + 1 == m_lat) begin
            if (m_cmp) begin
               m_result <= 8'h00;
               m_igual  <= (m_a == m_b);
               m_menor  <= (m_a < m_b);
            end else begin
               m_result <= {slice_f(m_op, m_a[7:4], m_b[7:4]), slice_f(m_op, m_a[3:0], m_b[3:0])};
               m_igual  <= 1'b0;
               m_menor  <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic       drive_hi, drive_lo;
      logic [3:0] ea, eb;
      logic [2:0] ex;
      drive_hi = (m_phase == 1);
      drive_lo = (m_phase == 2) && (m_lat == 3);
      ea = drive_hi ? m_a[7:4] : drive_lo ? m_a[3:0] : 4'h0;
      eb = drive_hi ? m_b[7:4] : drive_lo ? m_b[3:0] : 4'h0;
      ex = (drive_hi || drive_lo) ? m_op : 3'b000;
      check("busy",   int'(busy),   int'(m_phase != 0));
      check("done",   int'(done),   int'((m_phase != 0) && (m_phase == m_lat)));
      check("result", int'(result), int'(m_result));
      check("igual",  int'(igual),  int'(m_igual));
      check("menor",  int'(menor),  int'(m_menor));
      check("ula_a",  int'(ula_a),  int'(ea));
      check("ula_b",  int'(ula_b),  int'(eb));
      check("ula_x",  int'({x2, x1, x0}), int'(ex));
   end

   // Called just after a negedge in an idle cycle; returns one cycle after done.
   task automatic run_op(input logic [2:0] o, input logic c, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ei, input logic em, input int el);
      int n;
      #1;
      start = 1'b1; op = o; cmp = c; a = x; b = y;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("lit_ula_a_hi", int'(ula_a), int'(x[7:4]));
            #1;
            start = 1'b0; a = ~x; b = ~y; op = ~o; cmp = ~c;
         end
         if (n == 2 && el == 3) check("lit_ula_a_lo", int'(ula_a), int'(x[3:0]));
      end while (!done && n < 10);
      check("lit_latency", n, el);
      check("lit_result", int'(result), int'(er));
      check("lit_igual", int'(igual), int'(ei));
      check("lit_menor", int'(menor), int'(em));
      $display("op=%0d cmp=%0d a=%02h b=%02h -> result=%02h igual=%0d menor=%0d latency=%0d",
               o, c, x, y, result, igual, menor, n);
      @(negedge clk);
   endtask

   int early_lat;
   int ndone;

   initial begin
`ifdef ULA_SEQ_EARLY_EXIT_EN
      early_lat = 2;
`else
      early_lat = 3;
`endif
      // Reset held for 3 cycles with start high.
      rst_n = 1'b0; start = 1'b1; op = 3'b111; cmp = 1'b1; a = 8'hFF; b = 8'h11;
      repeat (3) @(negedge clk);
      check("lit_rst_busy", int'(busy), 0);
      check("lit_rst_done", int'(done), 0);
      check("lit_rst_result", int'(result), 0);
      check("lit_rst_flags", int'({igual, menor}), 0);
      check("lit_rst_ula", int'({ula_a, ula_b, x2, x1, x0}), 0);
      $display("reset: busy=%0d done=%0d result=%02h", busy, done, result);
      #1 start = 1'b0; rst_n = 1'b1;
      @(negedge clk);

      run_op(3'b010, 1'b0, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 3);
      run_op(3'b011, 1'b0, 8'h12, 8'h34, 8'h36, 1'b0, 1'b0, 3);
      run_op(3'b100, 1'b0, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 3);
      run_op(3'b110, 1'b0, 8'h98, 8'h87, 8'h1F, 1'b0, 1'b0, 3);
      run_op(3'b111, 1'b1, 8'h47, 8'h49, 8'h00, 1'b0, 1'b1, 3);
      run_op(3'b111, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 3);
      run_op(3'b111, 1'b1, 8'h91, 8'h2F, 8'h00, 1'b0, 1'b0, early_lat);
      run_op(3'b111, 1'b1, 8'h2F, 8'h91, 8'h00, 1'b0, 1'b1, early_lat);

      // Start held high with new operands while busy: must be ignored.
      #1 start = 1'b1; op = 3'b010; cmp = 1'b0; a = 8'hF0; b = 8'h3C;
      ndone = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 1) begin
            #1 a = 8'h0F; b = 8'hFF; op = 3'b011; cmp = 1'b1;
         end
         if (done) begin
            ndone++;
            check("lit_busy_result", int'(result), 8'h30);
            #1 start = 1'b0;
         end
      end
      start = 1'b0;
      check("lit_busy_dones", ndone, 1);
      $display("start-while-busy: done pulses=%0d result=%02h", ndone, result);

      // Reset pulsed during LO aborts without a done pulse.
      #1 start = 1'b1; op = 3'b011; cmp = 1'b0; a = 8'h81; b = 8'h18;
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("lit_abort_busy", int'(busy), 0);
      check("lit_abort_result", int'(result), 0);
      #1 rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("lit_abort_nodone", ndone, 0);
      $display("abort: done pulses after reset=%0d busy=%0d", ndone, busy);
      run_op(3'b101, 1'b0, 8'h3C, 8'h00, 8'hC3, 1'b0, 1'b0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ula8_seq_ctrl.md
# ula8_seq_ctrl

Multi-cycle controller that runs 8-bit operations on the shared 4-bit ULA slice by time-multiplexing it over the high and low nibbles. Sits between the processor's execute stage and the 4-bit ULA. Latches operands on a start/busy/done handshake, drives the slice's operand and select lines one nibble per cycle, and registers the merged 8-bit result and compare flags.

## Interface
- Parameters: none. Width is fixed at 8 bits, as two 4-bit nibbles.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; accepted only while busy=0.
- op  in  3  operation select; op[0], op[1], op[2] map to the slice's X0, X1, X2.
- cmp  in  1  1 = compare operation (merge flags), 0 = bitwise/logic operation (concatenate F).
- a, b  in  8  operands.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result, igual and menor are valid from this cycle.
- result  out  8  {F_hi, F_lo}; zero for compare operations.
- igual  out  1  8-bit A==B (compare only).
- menor  out  1  8-bit A<B (compare only).
- ula_a, ula_b  out  4  nibble operands to the slice.
- ula_x0, ula_x1, ula_x2  out  1  select lines to the slice.
- ula_f  in  4  slice F output.
- ula_igual, ula_menor  in  1  slice flags.

## Operation
- FSM states: IDLE, HI, LO, DONE. Encoding is 2 bits: 00, 01, 10, 11.
- IDLE:
  - ula_a, ula_b and ula_x* are driven to 0.
  - start=1 latches a, b, op and cmp into registers, then goes to HI.
- HI:
  - Drives ula_a=a_r[7:4], ula_b=b_r[7:4] and ula_x*=op_r.
  - Captures ula_f, ula_igual and ula_menor into hi registers at the cycle end.
  - Goes to LO. With ULA_SEQ_EARLY_EXIT_EN defined, goes to DONE instead when cmp_r=1 and ula_igual=0.
- LO: drives the low nibbles with the same op, captures the lo registers, goes to DONE.
- DONE: asserts done for one cycle, updates the output registers, goes to IDLE.
- Merge rules:
  - Logic operation: result={f_hi, f_lo}; igual and menor are cleared to 0.
  - Compare operation: igual = igual_hi & igual_lo; menor = menor_hi | (igual_hi & menor_lo); result=0.
  - On an early exit: igual=0 and menor=menor_hi.
- Output registers hold their value until the next DONE. They are not cleared when a new start is accepted.
- start while busy=1 is ignored. It is not queued.
- Operand changes after acceptance have no effect; only the latched copies are used.

## Timing
- Reset values: busy=0, done=0, result=0, igual=0, menor=0, ula_a=0, ula_b=0, ula_x*=0, state=IDLE.
- start is sampled high at edge 0. busy rises after edge 0. HI runs in cycle 1 and LO in cycle 2. done=1 and the outputs are valid in cycle 3. busy falls together with done.
- Early exit: done is valid in cycle 2.
- Throughput: a new start may be asserted in the DONE cycle. It is not accepted because busy=1. The earliest accepted start is the cycle after done, so one operation completes every 4 cycles.
- The slice is purely combinational. Its outputs are sampled in the same cycle its inputs are driven, so this path must close in one clock.
- Reset asserted mid-operation:
  - The FSM goes to IDLE immediately and all outputs return to their reset values.
  - No done pulse is produced for the aborted operation.

## Configuration
- ULA_SEQ_EARLY_EXIT_EN:
  - Defined: a compare whose high nibbles differ finishes after HI, with a latency of 2 cycles.
  - Undefined: every operation runs HI and LO, with a fixed latency of 3 cycles. The LO capture happens but does not change the merged result.

## Structure
- Shared package/header ula_defs:
  - FSM state constants (IDLE, HI, LO, DONE).
  - Op select constants for the slice.
  - The nibble width constant, value 4.
- One sub-module, ula8_merge: combinational merge of the hi/lo captures into result, igual and menor, including the early-exit case. The FSM and registers stay in the top module.

## Test plan
- Reset check: hold reset low for 3 cycles with start=1 -> busy=0, done=0, result=0, igual=0, menor=0, and all ula_* outputs 0.
- Logic op: op=3'b010, cmp=0, a=8'hA5, b=8'h3C, with the slice modelled as AND -> ula_a=4'hA in cycle 1 and 4'h5 in cycle 2; result=8'h24 with done in cycle 3.
- Compare, high nibbles equal: cmp=1, a=8'h47, b=8'h49 -> igual=0, menor=1 in cycle 3. Then a=8'h5A, b=8'h5A -> igual=1, menor=0.
- Compare, high nibbles differ: a=8'h91, b=8'h2F.
  - With ULA_SEQ_EARLY_EXIT_EN: done in cycle 2, igual=0, menor=0.
  - Without it: done in cycle 3 with the same flags.
- Start while busy: a second start with different operands in cycles 1–3 is ignored; the first operation's result is unchanged and only one done pulse occurs.
- Abort: reset pulsed low in cycle 2 (LO) -> state IDLE, no done. The next start completes normally with latency 3.
